// File: rtl/tx_resp_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_resp_packer
//  Description : Queues ALU results (16-bit) and register read data (8-bit)
//                and serialises each queued response into bytes for the TX
//                async FIFO write port. ALU entries emit two bytes, register
//                entries one byte. wfull holds the current byte in place.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_resp_packer #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [15:0]              ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic [7:0]               RdData,
    input  logic                     RdData_Valid,
    input  logic                     wfull,
    output logic [7:0]               TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 2;
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_ALU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2
    } state_t;

    // Queue storage: entry = {kind, data[15:0]}
    logic [16:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [7:0]     drop_q, drop_d;

    state_t         state_q;
    logic           hold_kind_q;
    logic [15:0]    hold_data_q;

    logic           pop_w;
    logic [FW-1:0]  free_w;
    logic           push_alu_w;
    logic           push_reg_w;
    logic           drop_alu_w;
    logic           drop_reg_w;
    logic [1:0]     n_push_w;
    logic [8:0]     drop_sum_w;
    logic [PW-1:0]  reg_wr_idx_w;
    logic [16:0]    head_w;
    logic [7:0]     first_byte_w;
    logic [7:0]     second_byte_w;
    logic           accept_w;

    // Push/pop arbitration, occupancy and drop accounting
    always_comb begin
        pop_w        = (state_q == ST_IDLE) && (count_q != '0);
        // A pop in this cycle frees a slot for a push in the same cycle
        free_w       = FW'(DEPTH) - {1'b0, count_q} + {{(FW-1){1'b0}}, pop_w};
        push_alu_w   = OUT_Valid && (free_w >= FW'(1));
        push_reg_w   = RdData_Valid && (free_w >= (push_alu_w ? FW'(2) : FW'(1)));
        drop_alu_w   = OUT_Valid & ~push_alu_w;
        drop_reg_w   = RdData_Valid & ~push_reg_w;
        n_push_w     = {1'b0, push_alu_w} + {1'b0, push_reg_w};
        reg_wr_idx_w = wr_ptr_q + {{(PW-1){1'b0}}, push_alu_w};
        wr_ptr_d     = wr_ptr_q + PW'(n_push_w);
        rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, pop_w};
        count_d      = count_q + (PW+1)'(n_push_w) - {{PW{1'b0}}, pop_w};
        drop_sum_w   = {1'b0, drop_q} + {8'd0, drop_alu_w} + {8'd0, drop_reg_w};
        drop_d       = drop_sum_w[8] ? 8'hFF : drop_sum_w[7:0];
        head_w       = mem_q[rd_ptr_q];
    end

    // Queue storage writes; ALU entry always takes the earlier slot
    always_ff @(posedge CLK) begin
        if (push_alu_w) begin
            mem_q[wr_ptr_q] <= {KIND_ALU, ALU_OUT};
        end
        if (push_reg_w) begin
            mem_q[reg_wr_idx_w] <= {KIND_REG, 8'h00, RdData};
        end
    end

    // Queue pointers, occupancy and saturating drop counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // A byte leaves only when a send state sees room in the FIFO
    assign accept_w = ~wfull;

    // Serialiser FSM: pop into holding register, then emit one or two bytes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            hold_kind_q <= KIND_REG;
            hold_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_w) begin
                        hold_kind_q <= head_w[16];
                        hold_data_q <= head_w[15:0];
                        state_q     <= ST_SEND_A;
                    end
                end
                ST_SEND_A: begin
                    if (accept_w) begin
                        state_q <= (hold_kind_q == KIND_ALU) ? ST_SEND_B : ST_IDLE;
                    end
                end
                ST_SEND_B: begin
                    if (accept_w) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte selection from the holding register by state and byte order
    always_comb begin
        first_byte_w  = hold_data_q[7:0];
        second_byte_w = hold_data_q[15:8];
        if (MSB_FIRST && (hold_kind_q == KIND_ALU)) begin
            first_byte_w  = hold_data_q[15:8];
            second_byte_w = hold_data_q[7:0];
        end
        case (state_q)
            ST_SEND_A: TX_P_DATA = first_byte_w;
            ST_SEND_B: TX_P_DATA = second_byte_w;
            default:   TX_P_DATA = 8'h00;
        endcase
    end

    // Write strobe is combinational so the byte lands in the same cycle
    assign TX_D_VLD = ((state_q == ST_SEND_A) || (state_q == ST_SEND_B)) && accept_w;
    assign busy     = (count_q != '0) || (state_q != ST_IDLE);
    assign q_count  = count_q;
    assign drop_cnt = drop_q;

endmodule
`default_nettype wire
